axi_master_tx: RTL and testbench

Transmit-side master for the valid/ready word link. Buffers words from a local producer in a small FIFO and presents them to the downstream receiver on `valid`/`data`. It obeys the link handshake: `valid` never depends on `ready`, and `data` is held stable until accepted. It sits directly upstream of the receiving slave stage and drives its `valid` and `data` inputs.

---
 rtl/axi_master_tx.sv | 112 +++++++++++
 tb/tb_axi_master_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_tx.sv
// Valid/ready transmit master: a small FIFO feeding a registered output stage.
// Optional transfer counter enabled by defining AXI_MASTER_TX_CNT_EN.
module axi_master_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     overflow,
    input  logic                     ready,
    output logic                     valid,
    output logic [DATA_W-1:0]        data,
    output logic [$clog2(DEPTH):0]   level
`ifdef AXI_MASTER_TX_CNT_EN
    ,
    output logic [15:0]              tx_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    logic transfer;
    logic out_free;
    logic fifo_empty;
    logic accept;
    logic pop;
    logic bypass;
    logic push;

    assign transfer   = valid & ready;
    assign out_free   = ~valid | transfer;
    assign fifo_empty = (count == '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign accept     = wr_en & ~full;
    // Buffered words always drain ahead of a new write, keeping strict order.
    assign pop        = out_free & ~fifo_empty;
    assign bypass     = out_free & fifo_empty & accept;
    assign push       = accept & ~bypass;
    assign level      = count;

    // NOTE: storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (out_free) begin
            if (pop) begin
                valid <= 1'b1;
                data  <= mem[rd_ptr];
            end else if (bypass) begin
                valid <= 1'b1;
                data  <= wr_data;
            end else begin
                valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef AXI_MASTER_TX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
        end else if (transfer) begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_master_tx.sv
// Directed bench for axi_master_tx with a queue scoreboard on the output link.
// Define AXI_MASTER_TX_CNT_EN to also exercise the transfer counter.
`timescale 1ns/1ps
module tb_axi_master_tx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              wr_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              ready   = 1'b0;
    logic              full;
    logic              overflow;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [2:0]        level;
`ifdef AXI_MASTER_TX_CNT_EN
    logic [15:0]       tx_cnt;
    int unsigned       exp_cnt = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    axi_master_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .ready    (ready),
        .valid    (valid),
        .data     (data),
        .level    (level)
`ifdef AXI_MASTER_TX_CNT_EN
        ,
        .tx_cnt   (tx_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples just before each rising edge, when the link values are settled.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    always begin
        @(posedge clk);
        #9;
        if (prev_stall) begin
            check("stall_valid", 32'(valid), 32'h1);
            check("stall_data", data, prev_data);
        end
        if (rst) begin
`ifdef AXI_MASTER_TX_CNT_EN
            exp_cnt = 0;
`endif
        end else if (valid && ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL extra_word: observed %0h expected no transfer", data);
            end else begin
                check("out_word", data, exp_q.pop_front());
            end
`ifdef AXI_MASTER_TX_CNT_EN
            exp_cnt++;
`endif
        end
        prev_stall = !rst && valid && !ready;
        prev_data  = data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] w, input bit accepted);
        wr_en   = 1'b1;
        wr_data = w;
        if (accepted) exp_q.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'h0);
    endtask

    int w;

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        rst = 1'b0;

        // Single word on an idle link
        ready = 1'b1;
        write(32'hA5A5_0001, 1'b1);
        check("s1_valid", 32'(valid), 32'h1);
        check("s1_data", data, 32'hA5A5_0001);
        check("s1_level", 32'(level), 32'h0);
        tick();
        check("s1_valid_after", 32'(valid), 32'h0);
        check("s1_level_after", 32'(level), 32'h0);

        // Fill with the receiver stalled, then drain back-to-back
        ready = 1'b0;
        for (int i = 0; i < 5; i++) write(32'(i), 1'b1);
        check("fill_full", 32'(full), 32'h1);
        check("fill_level", 32'(level), 32'h4);
        check("fill_overflow", 32'(overflow), 32'h0);
        write(32'd5, 1'b0);
        check("drop_overflow", 32'(overflow), 32'h1);
        check("drop_full", 32'(full), 32'h1);
        check("drop_level", 32'(level), 32'h4);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_valid", 32'(valid), 32'h1);
            check("b2b_level", 32'(level), 32'(3 - k));
        end
        tick();
        check("b2b_end_valid", 32'(valid), 32'h0);
        check("b2b_end_full", 32'(full), 32'h0);
        check("b2b_overflow_sticky", 32'(overflow), 32'h1);

        // Stream with ready toggling, including changes on the falling edge
        w = 0;
        for (int i = 0; i < 30; i++) begin
            ready = (i % 2 == 0);
            if ((i < 6 || i % 2 == 0) && w < 16) begin
                wr_en   = 1'b1;
                wr_data = 32'h10 + 32'(w);
                exp_q.push_back(32'h10 + 32'(w));
                w++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            ready = (i % 2 == 1);
            tick();
        end
        wr_en = 1'b0;
        ready = 1'b1;
        drain(20);
        tick();
        check("stream_idle", 32'(valid), 32'h0);

        // Simultaneous push and pop at level 2
        ready = 1'b0;
        write(32'hB0, 1'b1);
        write(32'hB1, 1'b1);
        write(32'hB2, 1'b1);
        check("pp_level_before", 32'(level), 32'h2);
        ready = 1'b1;
        write(32'hB3, 1'b1);
        check("pp_level_after", 32'(level), 32'h2);
        check("pp_head", data, 32'hB1);
        drain(10);
        tick();
        check("pp_idle", 32'(valid), 32'h0);

        // Reset mid-transfer discards everything
        ready = 1'b0;
        for (int i = 0; i < 4; i++) write(32'h50 + 32'(i), 1'b1);
        check("mr_level", 32'(level), 32'h3);
        check("mr_valid", 32'(valid), 32'h1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("mr_valid_clr", 32'(valid), 32'h0);
        check("mr_data_clr", data, 32'h0);
        check("mr_level_clr", 32'(level), 32'h0);
        check("mr_full_clr", 32'(full), 32'h0);
        check("mr_overflow_clr", 32'(overflow), 32'h0);
        ready = 1'b1;
        write(32'h77, 1'b1);
        check("mr_next_data", data, 32'h77);
        drain(5);

`ifdef AXI_MASTER_TX_CNT_EN
        // Counter wrap over 65537 transfers
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_rst", 32'(tx_cnt), 32'h0);
        ready = 1'b1;
        for (int n = 0; n < 65537; n++) write(32'(n), 1'b1);
        drain(5);
        tick();
        check("cnt_wrap", 32'(tx_cnt), exp_cnt & 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
